// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: requester ids and the in-flight tracking entry.
package mem_arb_pkg;

    localparam int N_REQ_MAX = 4;
    localparam int MEM_W_MAX = 512;
    localparam int OFF_W     = $clog2(MEM_W_MAX / 32);

    localparam int SRC_DATA  = 0;
    localparam int SRC_VLSU  = 1;
    localparam int SRC_INSTR = 2;

    typedef logic [$clog2(N_REQ_MAX)-1:0] src_id_t;

    // Lane offset is sized for the widest supported port; narrower ports leave the top bits 0.
    typedef struct packed {
        src_id_t          src;
        logic [OFF_W-1:0] off;
    } outst_entry_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side bundles of the memory port arbiter.
interface mem_arb_req_if #(
    parameter int N_REQ = 3,
    parameter int MEM_W = 32
);
    logic [N_REQ-1:0]                 req_i;
    logic [N_REQ-1:0]                 gnt_o;
    logic [N_REQ-1:0][31:0]           addr_i;
    logic [N_REQ-1:0]                 we_i;
    logic [N_REQ-1:0][MEM_W/8-1:0]    be_i;
    logic [N_REQ-1:0][MEM_W-1:0]      wdata_i;
    logic [N_REQ-1:0]                 rsp_valid_o;
    logic [MEM_W-1:0]                 rsp_rdata_o;
    logic [31:0]                      rsp_word_o;
    logic                             rsp_err_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i,
        input  gnt_o, rsp_valid_o, rsp_rdata_o, rsp_word_o, rsp_err_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i,
        output gnt_o, rsp_valid_o, rsp_rdata_o, rsp_word_o, rsp_err_o
    );
endinterface

interface mem_arb_mem_if #(
    parameter int MEM_W = 32
);
    logic               mem_req_o;
    logic               mem_gnt_i;
    logic [31:0]        mem_addr_o;
    logic               mem_we_o;
    logic [MEM_W/8-1:0] mem_be_o;
    logic [MEM_W-1:0]   mem_wdata_o;
    logic               mem_rvalid_i;
    logic [MEM_W-1:0]   mem_rdata_i;
    logic               mem_err_i;

    modport master (
        output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, mem_err_i
    );
endinterface

// File: rtl/mem_port_arbiter_fifo.sv
// In-order queue of outstanding transactions (issuer id + lane offset).
module mem_arb_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push,
    input  outst_entry_t           din,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output outst_entry_t           head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    outst_entry_t     store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count == ($clog2(DEPTH) + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];

    // Entry storage carries no reset; validity is defined by count and the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            store[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between N_REQ requesters and routes in-order responses back.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration (default: fixed priority).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_W     = 32,
    parameter int N_REQ     = 3,
    parameter int MAX_OUTST = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    mem_arb_req_if.slave               req_bus,
    mem_arb_mem_if.master              mem_bus,
    output logic [$clog2(MAX_OUTST):0] outst_o
);

    localparam int LANES = MEM_W / 32;

    logic         any_req;
    src_id_t      winner;
    logic         win_vld;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    outst_entry_t push_entry;
    outst_entry_t head;

    function automatic logic [OFF_W-1:0] lane_of(input logic [31:0] addr);
        return OFF_W'((addr >> 2) & 32'(LANES - 1));
    endfunction

`ifdef MEM_ARB_RR_EN
    src_id_t rr_ptr;

    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any_req && req_bus.req_i[src_id_t'((int'(rr_ptr) + k) % N_REQ)]) begin
                any_req = 1'b1;
                winner  = src_id_t'((int'(rr_ptr) + k) % N_REQ);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (push) begin
            rr_ptr <= (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
        end
    end
`else
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any_req && req_bus.req_i[src_id_t'(k)]) begin
                any_req = 1'b1;
                winner  = src_id_t'(k);
            end
        end
    end
`endif

    // Full blocks on the registered count, so a same-cycle pop cannot unblock a request.
    assign win_vld = any_req && !full;
    assign push    = win_vld && mem_bus.mem_gnt_i;
    assign pop     = mem_bus.mem_rvalid_i && !empty;

    always_comb begin
        mem_bus.mem_req_o   = win_vld;
        mem_bus.mem_addr_o  = '0;
        mem_bus.mem_we_o    = 1'b0;
        mem_bus.mem_be_o    = '0;
        mem_bus.mem_wdata_o = '0;
        req_bus.gnt_o       = '0;
        if (win_vld) begin
            mem_bus.mem_addr_o  = req_bus.addr_i[winner];
            mem_bus.mem_we_o    = req_bus.we_i[winner];
            mem_bus.mem_be_o    = req_bus.be_i[winner];
            mem_bus.mem_wdata_o = req_bus.wdata_i[winner];
        end
        if (push) begin
            req_bus.gnt_o[winner] = 1'b1;
        end
    end

    assign push_entry.src = winner;
    assign push_entry.off = lane_of(req_bus.addr_i[winner]);

    mem_arb_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .din    (push_entry),
        .pop    (pop),
        .full   (full),
        .empty  (empty),
        .count  (outst_o),
        .head   (head)
    );

    always_comb begin
        req_bus.rsp_valid_o = '0;
        req_bus.rsp_rdata_o = '0;
        req_bus.rsp_word_o  = '0;
        req_bus.rsp_err_o   = 1'b0;
        if (pop) begin
            req_bus.rsp_valid_o[head.src] = 1'b1;
            req_bus.rsp_rdata_o           = mem_bus.mem_rdata_i;
            req_bus.rsp_err_o             = mem_bus.mem_err_i;
            for (int i = 0; i < LANES; i++) begin
                if (head.off == OFF_W'(i)) begin
                    req_bus.rsp_word_o = mem_bus.mem_rdata_i[i*32 +: 32];
                end
            end
        end
    end

    // A response with nothing in flight has no owner; it is dropped and flagged here.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(mem_bus.mem_rvalid_i && empty))
                else $warning("mem_port_arbiter: rvalid with no outstanding transaction, response dropped");
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter on a 128-bit port with three requesters.
module tb_mem_port_arbiter;

    localparam int MEM_W     = 128;
    localparam int N_REQ     = 3;
    localparam int MAX_OUTST = 4;

    typedef struct {
        int src;
        int off;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [$clog2(MAX_OUTST):0] outst;

    exp_t exp_q[$];
    int   m_cnt;
    int   m_rr;
    int   n_cmp;
    int   n_err;

    mem_arb_req_if #(.N_REQ(N_REQ), .MEM_W(MEM_W)) rb ();
    mem_arb_mem_if #(.MEM_W(MEM_W)) mb ();

    mem_port_arbiter #(
        .MEM_W     (MEM_W),
        .N_REQ     (N_REQ),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_bus (rb),
        .mem_bus (mb),
        .outst_o (outst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner(input logic [2:0] r, input int rr);
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < N_REQ; k++) if (r[2'((rr + k) % N_REQ)]) return (rr + k) % N_REQ;
`else
        for (int k = 0; k < N_REQ; k++) if (r[2'(k)]) return k;
`endif
        return 0;
    endfunction

    task automatic idle();
        rb.req_i        = '0;
        rb.we_i         = '0;
        mb.mem_gnt_i    = 1'b1;
        mb.mem_rvalid_i = 1'b0;
        mb.mem_rdata_i  = '0;
        mb.mem_err_i    = 1'b0;
    endtask

    task automatic set_req(input int idx, input logic [31:0] addr, input logic we);
        rb.req_i[idx]   = 1'b1;
        rb.addr_i[idx]  = addr;
        rb.we_i[idx]    = we;
        rb.be_i[idx]    = {(MEM_W/8){1'b1}};
        rb.wdata_i[idx] = {4{addr}};
    endtask

    // One clock: check combinational outputs mid-cycle against the model, then advance the model.
    task automatic step();
        int           w;
        logic         emreq;
        logic         do_grant;
        logic         do_pop;
        logic [2:0]   eg;
        logic [2:0]   ev;
        logic [31:0]  ew;
        logic [127:0] rd;
        exp_t         e;
        @(negedge clk);
        w        = model_winner(rb.req_i, m_rr);
        emreq    = (rb.req_i != '0) && (m_cnt < MAX_OUTST);
        do_grant = emreq && mb.mem_gnt_i;
        do_pop   = mb.mem_rvalid_i && (exp_q.size() > 0);
        eg       = do_grant ? 3'(1 << w) : 3'b000;
        rd       = mb.mem_rdata_i;
        chk("mem_req", mb.mem_req_o, emreq);
        chk("gnt", rb.gnt_o, eg);
        chk("mem_addr", mb.mem_addr_o, emreq ? rb.addr_i[w] : 32'h0);
        chk("mem_we", mb.mem_we_o, emreq ? rb.we_i[w] : 1'b0);
        chk("outst", outst, m_cnt);
        ev = 3'b000;
        ew = 32'h0;
        if (do_pop) begin
            e  = exp_q[0];
            ev = 3'(1 << e.src);
            ew = rd[e.off*32 +: 32];
            chk("rsp_rdata", rb.rsp_rdata_o, rd);
            chk("rsp_err", rb.rsp_err_o, mb.mem_err_i);
        end
        chk("rsp_valid", rb.rsp_valid_o, ev);
        chk("rsp_word", rb.rsp_word_o, ew);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            m_rr = 0;
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_grant) begin
                exp_q.push_back('{w, int'((rb.addr_i[w] >> 2) & 32'h3)});
                m_rr = (w + 1) % N_REQ;
            end
        end
        m_cnt = exp_q.size();
    endtask

    task automatic resp(input logic [127:0] data, input logic err);
        idle();
        mb.mem_rvalid_i = 1'b1;
        mb.mem_rdata_i  = data;
        mb.mem_err_i    = err;
        step();
        idle();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_cnt = 0;
        m_rr  = 0;
        rb.addr_i  = '0;
        rb.be_i    = '0;
        rb.wdata_i = '0;
        idle();
        rst_n = 1'b0;
        step();
        step();
        chk("rst_outst", outst, 0);
        chk("rst_rsp_valid", rb.rsp_valid_o, 0);
        rst_n = 1'b1;
        step();

        // Single data read, response two cycles after the grant
        set_req(0, 32'h100, 1'b0);
        step();
        idle();
        chk("t1_outst", outst, 1);
        step();
        resp({96'h0, 32'hDEADBEEF}, 1'b0);
        chk("t1_outst_after", outst, 0);

        // Contention: three cycles of all requesters, then data drops out
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < N_REQ; r++) set_req(r, 32'h1000 + 32'(r * 16 + i * 4), 1'b0);
            step();
        end
        rb.req_i[0] = 1'b0;
        step();
        for (int i = 0; i < 4; i++) resp({4{32'(i) * 32'h01010101}}, 1'b0);
        idle();

        // Fill to MAX_OUTST, a same-cycle pop does not unblock, then grants resume
        for (int i = 0; i < MAX_OUTST; i++) begin
            set_req(0, 32'h400 + 32'(i * 4), i[0]);
            step();
        end
        chk("t3_full_outst", outst, MAX_OUTST);
        set_req(0, 32'h500, 1'b0);
        mb.mem_rvalid_i = 1'b1;
        mb.mem_rdata_i  = 128'h1;
        step();
        mb.mem_rvalid_i = 1'b0;
        step();
        idle();
        for (int i = 0; i < MAX_OUTST; i++) resp({32'h0, 32'(i), 32'hA5A5A5A5, 32'h5A5A5A5A}, i == 2);

        // Memory stall: request held while mem_gnt_i is low
        set_req(1, 32'h2000, 1'b1);
        mb.mem_gnt_i = 1'b0;
        step();
        step();
        mb.mem_gnt_i = 1'b1;
        step();
        idle();
        resp(128'hCAFE, 1'b1);

        // Interleaved instr then data responses, plus 128-bit lane select at 0x88
        set_req(2, 32'h80, 1'b0);
        step();
        idle();
        set_req(0, 32'h200, 1'b0);
        step();
        idle();
        set_req(2, 32'h88, 1'b0);
        step();
        idle();
        resp(128'h11111111, 1'b0);
        resp(128'h22222222, 1'b0);
        mb.mem_rvalid_i = 1'b1;
        mb.mem_rdata_i  = 128'h44444444_33333333_22222222_11111111;
        #1;
        chk("t5_word", rb.rsp_word_o, 32'h33333333);
        chk("t5_valid", rb.rsp_valid_o, 3'b100);
        step();
        idle();

        // Random traffic; responses only when something is in flight
        for (int c = 0; c < 300; c++) begin
            idle();
            for (int r = 0; r < N_REQ; r++) begin
                if ($urandom_range(0, 1) == 1) set_req(r, $urandom & 32'hFFFC, 1'($urandom_range(0, 1)));
            end
            mb.mem_gnt_i = 1'($urandom_range(0, 3) != 0);
            if (exp_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                mb.mem_rvalid_i = 1'b1;
                mb.mem_rdata_i  = {$urandom, $urandom, $urandom, $urandom};
                mb.mem_err_i    = 1'($urandom_range(0, 7) == 0);
            end
            step();
        end
        idle();
        while (exp_q.size() > 0) resp({$urandom, $urandom, $urandom, $urandom}, 1'b0);

        // Reset with two outstanding, then a stray response is dropped
        set_req(0, 32'h10, 1'b0);
        step();
        set_req(0, 32'h20, 1'b0);
        step();
        idle();
        chk("t6_outst_pre", outst, 2);
        rst_n = 1'b0;
        exp_q.delete();
        m_cnt = 0;
        m_rr  = 0;
        #1;
        chk("t6_outst_rst", outst, 0);
        step();
        rst_n = 1'b1;
        resp(128'hBAD, 1'b0);
        chk("t6_outst_post", outst, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
